seven_seg_scanner: RTL

//  Time-multiplexed digit scanner that sits directly upstream of the 4-bit hex-to-7-segment decoder.

---
 rtl/seven_seg_scanner.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed hex digit scanner with an all-anodes-off guard at the start of every slot.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scanner #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16,
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int PRE_W      = $clog2(REFRESH_DIV)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [3:0]            nibble,
  output logic                  dp,
  output logic [DIGITS-1:0]     an_n,
  output logic [IDX_W-1:0]      digit_idx
);

  localparam logic [PRE_W-1:0] PRE_GUARD_END = PRE_W'(GUARD - 1);
  localparam logic [PRE_W-1:0] PRE_SLOT_END  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {S_OFF, S_GUARD, S_SHOW} state_t;

  state_t              state, state_nxt;
  logic [PRE_W-1:0]    pre, pre_nxt;
  logic [IDX_W-1:0]    idx_nxt;
  logic                to_show;

  logic [4*DIGITS-1:0] shadow_val, src_val;
  logic [DIGITS-1:0]   shadow_dp, src_dp;
  logic                loaded;
  logic [3:0]          sel_nib;
  logic                sel_dp;

  logic [3:0]          nibble_nxt;
  logic                dp_nxt;
  logic [DIGITS-1:0]   an_nxt;

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // Digit k>0 is blank when it and every higher digit has a zero nibble and an unlit dp.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] v,
                                                input logic [DIGITS-1:0] d);
    logic [DIGITS-1:0] m;
    logic              zero_run;
    m        = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (v[4*k +: 4] == 4'h0) && !d[k];
      m[k]     = zero_run;
    end
    return m;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      loaded     <= 1'b0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp_in;
      loaded     <= 1'b1;
    end
  end

  // A load on the sampling edge writes straight through to the digit selector.
  always_comb begin
    src_val = load ? value : shadow_val;
    src_dp  = load ? dp_in : shadow_dp;
    sel_nib = 4'h0;
    sel_dp  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_idx == k[IDX_W-1:0]) begin
        sel_nib = src_val[4*k +: 4];
        sel_dp  = src_dp[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_OFF;
      pre       <= '0;
      digit_idx <= '0;
    end else begin
      state     <= state_nxt;
      pre       <= pre_nxt;
      digit_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pre_nxt   = pre;
    idx_nxt   = digit_idx;
    to_show   = 1'b0;
    if (!enable) begin
      state_nxt = S_OFF;
      pre_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        S_OFF: begin
          pre_nxt = '0;
          idx_nxt = '0;
          if (loaded) state_nxt = S_GUARD;
        end
        S_GUARD: begin
          pre_nxt = pre + 1'b1;
          if (pre == PRE_GUARD_END) begin
            state_nxt = S_SHOW;
            to_show   = 1'b1;
          end
        end
        S_SHOW: begin
          if (pre == PRE_SLOT_END) begin
            pre_nxt   = '0;
            state_nxt = S_GUARD;
            idx_nxt   = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
          end else begin
            pre_nxt = pre + 1'b1;
          end
        end
        default: begin
          state_nxt = S_OFF;
          pre_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are registered versions of the next-state view; nibble/dp only change on entry to SHOW.
  always_comb begin
    nibble_nxt = nibble;
    dp_nxt     = dp;
    an_nxt     = an_n;
    if (state_nxt != S_SHOW) an_nxt = '1;
    if (to_show) begin
      nibble_nxt = sel_nib;
      dp_nxt     = sel_dp;
      for (int k = 0; k < DIGITS; k++) an_nxt[k] = (digit_idx != k[IDX_W-1:0]);
`ifdef SEVEN_SEG_LZ_BLANK_EN
      if ((lz_mask(src_val, src_dp) & ~an_nxt) != '0) an_nxt = '1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nibble <= 4'h0;
      dp     <= 1'b0;
      an_n   <= '1;
    end else begin
      nibble <= nibble_nxt;
      dp     <= dp_nxt;
      an_n   <= an_nxt;
    end
  end

endmodule
